tea_decipher_feeder: RTL
========================

Name: tea_decipher_feeder

Overview:
Upstream stage for the TEA decipher core.
- Assembles a 128-bit key and 64-bit ciphertext blocks from a byte-serial stream.
- Drives the core's level-sensitive start (low = core held in reset and loading iV0/iV1), and waits for its done flag.
- Captures the plaintext and presents it on a valid/ready output handshake.
- Includes a watchdog that aborts a run if the core never completes.

Parameters:
- WORD_SIZE, 32, width of V/K/C words.
- TIMEOUT_CYCLES, 1024, maximum cycles in RUN before abort (a full decipher takes about 416 cycles).
- CNT_BITS, $clog2(TIMEOUT_CYCLES+1), watchdog counter width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- iByte  in  8  input byte.
- iByteValid  in  1  iByte valid.
- iKeyLoad  in  1  qualifies each byte: 1 = key byte, 0 = ciphertext byte.
- oByteReady  out  1  byte accepted when iByteValid & oByteReady.
- oV0, oV1  out  WORD_SIZE  ciphertext words to the core.
- oK0..oK3  out  WORD_SIZE  key words to the core.
- oStart  out  1  core enable (level).
- iDone  in  1  core done flag.
- iC0, iC1  in  WORD_SIZE  core plaintext outputs.
- oP0, oP1  out  WORD_SIZE  captured plaintext.
- oPValid  out  1  plaintext valid.
- iPReady  in  1  downstream ready.
- oKeyValid  out  1  a full key is loaded.
- oErr  out  1  one-cycle error pulse.

Behaviour:
Reset (async, rst_n=0):
- All outputs 0, state LOAD, byte counter 0, oByteReady 0.
- oByteReady is 1 from the first clk after reset release while in LOAD.

Byte packing (big-endian):
- Key: byte 0 → oK0[31:24] … byte 15 → oK3[7:0].
- Data: byte 0 → oV0[31:24] … byte 7 → oV1[7:0].
- Writes go directly into the oK*/oV* registers.

State LOAD (oByteReady=1, oStart=0):
- Each accepted byte increments a 4-bit counter.
- Mode is the iKeyLoad value at the frame's first byte.
- If iKeyLoad differs from the frame mode on an accepted byte, the counter restarts and that byte becomes byte 0 of a new frame in the new mode; partial words keep stale bytes.
- Key frame: on the 16th byte, oKeyValid←1 and the counter clears. Stay in LOAD.
- Data frame: on the 8th byte the counter clears, then:
  - with oKeyValid=1, go to RUN next cycle;
  - with oKeyValid=0, pulse oErr and discard the block (stay in LOAD).
- Starting a new key frame clears oKeyValid on its first byte.

State RUN:
- oStart=1 and oByteReady=0; oV*/oK* are held stable.
- The watchdog counts cycles from 0.
- iDone=1: capture oP0←iC0 and oP1←iC1, drop oStart next cycle (this resets the core), go to OUT.
- Watchdog reaches TIMEOUT_CYCLES first: oStart←0, pulse oErr, return to LOAD, no output.

State OUT:
- oPValid=1 with oP* stable.
- On iPReady & oPValid: oPValid←0, go to LOAD; oByteReady rises the same edge.
- oP0/oP1 hold their last values after the handshake.

Rules:
- oStart is low for at least one cycle between consecutive blocks, so the core always reloads iV0/iV1.
- Key persists across blocks until a new key frame begins.
- Reset mid-RUN or mid-OUT: everything clears immediately (async), the pending block is lost, oKeyValid=0.
- iDone is ignored outside RUN.
- Only state, counters and capture registers are sequential; no combinational path from iByte to any output.

Decomposition:
- Package tea_pkg holds:
  - state encoding constants: LOAD=2'd0, RUN=2'd1, OUT=2'd2;
  - DELTA 32'h9e3779b9, shared with the core;
  - the initial decipher sum 32'hC6EF3720;
  - KEY_BYTES=16 and BLOCK_BYTES=8.
- Sub-module tea_byte_packer: byte-to-word shift/packing, with counter and mode-change restart.
- The FSM and watchdog stay in the top module.
- The testbench instantiates the feeder with the existing decipher core.

Test Plan:
1. Key bytes 16×00, then data bytes 41 EA 3A 0A 94 BA A9 40 → oStart high about 416 cycles; oP0=00000000, oP1=00000000, oPValid=1 until iPReady.
2. Data block sent before any key → oErr pulses one cycle after the 8th byte, oStart stays 0, oByteReady stays 1.
3. Two back-to-back blocks with iPReady held 0 for 20 cycles on the first → oPValid held 20 cycles with oP stable, oByteReady=0 throughout, oStart low ≥1 cycle between runs, second result correct.
4. Key frame interrupted after 5 bytes by a data byte (iKeyLoad=0) → frame restarts in data mode, oKeyValid stays 0, an eventual 8-byte block gives oErr.
5. Core stub with iDone tied 0 → after 1024 RUN cycles oStart←0, oErr pulses, return to LOAD.
6. rst_n asserted mid-RUN (cycle 100) → all outputs 0 asynchronously, oKeyValid=0; after release a full key+block sequence decrypts correctly.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared constants for the TEA decipher feeder and core: FSM encoding,
// round constants and byte counts of the key and data frames.
package tea_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [31:0] DELTA    = 32'h9e3779b9;
    localparam logic [31:0] SUM_INIT = 32'hC6EF3720;

    localparam int KEY_BYTES   = 16;
    localparam int BLOCK_BYTES = 8;

    // Index of the final byte of an n-byte frame, sized for the byte counter.
    function automatic logic [3:0] last_idx(input int n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/tea_byte_packer.sv
// Big-endian byte-to-word packer for the TEA key and ciphertext block.
// A change of iKeyLoad mid-frame restarts the frame in the new mode.
module tea_byte_packer
    import tea_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_i,
    input  logic                     accept_i,
    input  logic                     key_load_i,
    output logic [8*KEY_BYTES-1:0]   key_o,
    output logic [8*BLOCK_BYTES-1:0] blk_o,
    output logic                     key_valid_o,
    output logic                     blk_done_o
);

    logic [3:0]               cnt_q, cnt_d;
    logic                     mode_q, mode_d;
    logic                     key_valid_q, key_valid_d;
    logic [8*KEY_BYTES-1:0]   key_q;
    logic [8*BLOCK_BYTES-1:0] blk_q;
    logic                     new_frame;
    logic [3:0]               idx;
    logic                     key_wr;
    logic                     blk_wr;

    always_comb begin
        new_frame   = (cnt_q == 4'd0) || (key_load_i != mode_q);
        idx         = new_frame ? 4'd0 : cnt_q;
        key_wr      = accept_i && key_load_i;
        blk_wr      = accept_i && !key_load_i;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        key_valid_d = key_valid_q;
        blk_done_o  = 1'b0;
        if (accept_i) begin
            mode_d = key_load_i;
            cnt_d  = idx + 4'd1;
            if (key_load_i) begin
                // The old key is no longer trustworthy once a new key frame starts.
                if (new_frame) begin
                    key_valid_d = 1'b0;
                end
                if (idx == last_idx(KEY_BYTES)) begin
                    key_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                end
            end else if (idx == last_idx(BLOCK_BYTES)) begin
                cnt_d      = 4'd0;
                blk_done_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 4'd0;
            mode_q      <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Bytes land straight in the word registers; byte 0 is the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
        end else if (key_wr) begin
            for (int b = 0; b < KEY_BYTES; b++) begin
                if (idx == 4'(b)) begin
                    key_q[8*(KEY_BYTES-b)-1 -: 8] <= byte_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
        end else if (blk_wr) begin
            for (int b = 0; b < BLOCK_BYTES; b++) begin
                if (idx == 4'(b)) begin
                    blk_q[8*(BLOCK_BYTES-b)-1 -: 8] <= byte_i;
                end
            end
        end
    end

    assign key_o       = key_q;
    assign blk_o       = blk_q;
    assign key_valid_o = key_valid_q;

endmodule

// File: rtl/tea_decipher_feeder.sv
// Feeds the TEA decipher core: loads key/ciphertext bytes, runs the core with
// a watchdog, and hands the plaintext downstream over a valid/ready port.
module tea_decipher_feeder
    import tea_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_BITS       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           iByte,
    input  logic                 iByteValid,
    input  logic                 iKeyLoad,
    output logic                 oByteReady,
    output logic [WORD_SIZE-1:0] oV0,
    output logic [WORD_SIZE-1:0] oV1,
    output logic [WORD_SIZE-1:0] oK0,
    output logic [WORD_SIZE-1:0] oK1,
    output logic [WORD_SIZE-1:0] oK2,
    output logic [WORD_SIZE-1:0] oK3,
    output logic                 oStart,
    input  logic                 iDone,
    input  logic [WORD_SIZE-1:0] iC0,
    input  logic [WORD_SIZE-1:0] iC1,
    output logic [WORD_SIZE-1:0] oP0,
    output logic [WORD_SIZE-1:0] oP1,
    output logic                 oPValid,
    input  logic                 iPReady,
    output logic                 oKeyValid,
    output logic                 oErr,
    output logic [1:0]           oState
);

    // Handshakes: a byte moves on a clk edge where iByteValid && oByteReady;
    // a plaintext moves on a clk edge where oPValid && iPReady. oPValid,
    // once raised, stays high with oP0/oP1 stable until that edge.

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    wd_q, wd_d;
    logic                   start_q, start_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic                   pvalid_q, pvalid_d;
    logic [WORD_SIZE-1:0]   p0_q, p0_d;
    logic [WORD_SIZE-1:0]   p1_q, p1_d;
    logic [8*KEY_BYTES-1:0] key_w;
    logic [8*BLOCK_BYTES-1:0] blk_w;
    logic                   key_valid;
    logic                   blk_done;
    logic                   accept;

    assign accept = iByteValid && ready_q;

    tea_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_i     (iByte),
        .accept_i   (accept),
        .key_load_i (iKeyLoad),
        .key_o      (key_w),
        .blk_o      (blk_w),
        .key_valid_o(key_valid),
        .blk_done_o (blk_done)
    );

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        err_d    = 1'b0;
        pvalid_d = pvalid_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        case (state_q)
            LOAD: begin
                if (blk_done) begin
                    if (key_valid) begin
                        state_d = RUN;
                        wd_d    = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (iDone) begin
                    p0_d     = iC0;
                    p1_d     = iC1;
                    pvalid_d = 1'b1;
                    state_d  = OUT;
                end else if (wd_q == CNT_BITS'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = LOAD;
                end else begin
                    wd_d = wd_q + CNT_BITS'(1);
                end
            end
            OUT: begin
                if (iPReady && pvalid_q) begin
                    pvalid_d = 1'b0;
                    state_d  = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        // Leaving RUN always drops start for at least one cycle, so the core
        // reloads iV0/iV1 before the next block.
        start_d = (state_d == RUN);
        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            wd_q     <= '0;
            start_q  <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            pvalid_q <= 1'b0;
            p0_q     <= '0;
            p1_q     <= '0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            start_q  <= start_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            pvalid_q <= pvalid_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
        end
    end

    assign oK0 = key_w[4*WORD_SIZE-1 -: WORD_SIZE];
    assign oK1 = key_w[3*WORD_SIZE-1 -: WORD_SIZE];
    assign oK2 = key_w[2*WORD_SIZE-1 -: WORD_SIZE];
    assign oK3 = key_w[WORD_SIZE-1:0];
    assign oV0 = blk_w[2*WORD_SIZE-1 -: WORD_SIZE];
    assign oV1 = blk_w[WORD_SIZE-1:0];

    assign oByteReady = ready_q;
    assign oStart     = start_q;
    assign oErr       = err_q;
    assign oPValid    = pvalid_q;
    assign oP0        = p0_q;
    assign oP1        = p1_q;
    assign oKeyValid  = key_valid;
    assign oState     = state_q;

endmodule
